// File: rtl/rpn_stack_sched.sv
// Postfix expression sequencer: drives an external operand stack through
// push/pop strobes, executes binary operators and reports the final value.
module rpn_stack_sched #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tok_vld_i,
  output logic               tok_rdy_o,
  input  logic [1:0]         tok_type_i,
  input  logic [WIDTH-1:0]   tok_dat_i,
  input  logic               clr_i,
  output logic               push_stb_o,
  output logic [WIDTH-1:0]   push_dat_o,
  output logic               pop_stb_o,
  input  logic [WIDTH-1:0]   pop_dat_i,
  output logic               stk_clr_o,
  output logic               res_vld_o,
  output logic [WIDTH-1:0]   res_dat_o,
  output logic               err_o,
  output logic [2:0]         err_code_o,
  output logic [DEPTH_W-1:0] depth_cnt_o
);

  typedef enum logic [3:0] {
    IDLE, POP_B, CAP_B, CAP_A, PUSH,
    FIN_POP, FIN_CAP, DONE, ERROR
  } state_e;

  typedef enum logic [1:0] {
    T_OPND = 2'b00,
    T_OPER = 2'b01,
    T_END  = 2'b10,
    T_RSVD = 2'b11
  } tok_e;

  typedef enum logic [2:0] {
    E_NONE  = 3'd0,
    E_UNDER = 3'd1,
    E_OVER  = 3'd2,
    E_END   = 3'd3,
    E_RSVD  = 3'd4
  } err_e;

  localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DTWO = DEPTH_W'(2);
  localparam logic [DEPTH_W-1:0] DONE_D = DEPTH_W'(1);

  state_e             state_q;
  logic               rdy_q;
  logic               push_stb_q;
  logic [WIDTH-1:0]   push_dat_q;
  logic               pop_stb_q;
  logic               stk_clr_q;
  logic               res_vld_q;
  logic [WIDTH-1:0]   res_dat_q;
  logic               err_q;
  err_e               code_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   b_q;

  logic acc;
  logic fail;
  err_e fcode;
  tok_e ttype;

  function automatic logic [WIDTH-1:0] alu(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    unique case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = a * b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign ttype = tok_e'(tok_type_i);
  assign acc   = tok_vld_i & rdy_q & ~clr_i;

  // Legality of the offered token against the current occupancy
  always_comb begin
    fail  = 1'b0;
    fcode = E_NONE;
    unique case (ttype)
      T_OPND: begin
        fail  = (depth_q == DMAX);
        fcode = E_OVER;
      end
      T_OPER: begin
        fail  = (depth_q < DTWO);
        fcode = E_UNDER;
      end
      T_END: begin
        fail  = (depth_q != DONE_D);
        fcode = E_END;
      end
      default: begin
        fail  = 1'b1;
        fcode = E_RSVD;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      push_stb_q <= 1'b0;
      push_dat_q <= '0;
      pop_stb_q  <= 1'b0;
      stk_clr_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      res_dat_q  <= '0;
      err_q      <= 1'b0;
      code_q     <= E_NONE;
      depth_q    <= '0;
      op_q       <= 2'd0;
      b_q        <= '0;
    end else begin
      push_stb_q <= 1'b0;
      pop_stb_q  <= 1'b0;
      stk_clr_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      if (clr_i) begin
        state_q   <= IDLE;
        depth_q   <= '0;
        err_q     <= 1'b0;
        code_q    <= E_NONE;
        stk_clr_q <= 1'b1;
        rdy_q     <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            rdy_q <= 1'b1;
            if (acc && fail) begin
              state_q <= ERROR;
              err_q   <= 1'b1;
              code_q  <= fcode;
              rdy_q   <= 1'b0;
            end else if (acc) begin
              unique case (ttype)
                T_OPND: begin
                  push_stb_q <= 1'b1;
                  push_dat_q <= tok_dat_i;
                  depth_q    <= depth_q + 1'b1;
                end
                T_OPER: begin
                  op_q      <= tok_dat_i[1:0];
                  pop_stb_q <= 1'b1;
                  rdy_q     <= 1'b0;
                  state_q   <= POP_B;
                end
                default: begin
                  pop_stb_q <= 1'b1;
                  rdy_q     <= 1'b0;
                  state_q   <= FIN_POP;
                end
              endcase
            end
          end
          POP_B: begin
            pop_stb_q <= 1'b1;
            state_q   <= CAP_B;
          end
          CAP_B: begin
            b_q     <= pop_dat_i;
            state_q <= CAP_A;
          end
          // Deeper operand arrives last; it is the left-hand side
          CAP_A: begin
            push_dat_q <= alu(op_q, pop_dat_i, b_q);
            push_stb_q <= 1'b1;
            depth_q    <= depth_q - 1'b1;
            state_q    <= PUSH;
          end
          PUSH: begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
          FIN_POP: state_q <= FIN_CAP;
          FIN_CAP: begin
            res_dat_q <= pop_dat_i;
            res_vld_q <= 1'b1;
            depth_q   <= '0;
            state_q   <= DONE;
          end
          DONE: begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: begin
            rdy_q   <= 1'b0;
            state_q <= ERROR;
          end
        endcase
      end
    end
  end

  // A clear in the push cycle must kill the write of an abandoned result
  assign push_stb_o  = push_stb_q & ~clr_i;
  assign push_dat_o  = push_dat_q;
  assign pop_stb_o   = pop_stb_q;
  assign tok_rdy_o   = rdy_q;
  assign stk_clr_o   = stk_clr_q;
  assign res_vld_o   = res_vld_q;
  assign res_dat_o   = res_dat_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign depth_cnt_o = depth_q;

endmodule

// File: doc/rpn_stack_sched.md
Name: rpn_stack_sched

Overview:
- Token-level controller that evaluates postfix (reverse Polish) expressions by sequencing the shared operand stack through its push/pop strobe interface.
- Sits between the tokenizer, which feeds operand/operator/end tokens, and the stack.
- Tracks stack depth internally, executes binary operators, returns the final result, and flags malformed expressions.

Parameters:
- WIDTH, 32, operand/result data width.
- DEPTH, 16, stack capacity in entries; must match the attached stack.
- DEPTH_W (localparam), $clog2(DEPTH+1), width of the depth counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- TOK_VLD  in  1  token valid.
- TOK_RDY  out  1  token ready; a token transfers when TOK_VLD & TOK_RDY.
- TOK_TYPE  in  2  00 operand, 01 operator, 10 end-of-expression, 11 reserved.
- TOK_DAT  in  WIDTH  operand value, or operator code in [1:0]: 0 ADD, 1 SUB, 2 MUL, 3 AND.
- CLR  in  1  synchronous clear pulse; aborts the expression and clears the error.
- PUSH_STB  out  1  stack push strobe.
- PUSH_DAT  out  WIDTH  stack push data.
- POP_STB  out  1  stack pop strobe.
- POP_DAT  in  WIDTH  stack pop data, valid the cycle after POP_STB.
- STK_CLR  out  1  one-cycle stack flush pulse.
- RES_VLD  out  1  one-cycle result strobe.
- RES_DAT  out  WIDTH  final result; holds until the next RES_VLD.
- ERR  out  1  sticky error flag.
- ERR_CODE  out  3  0 none, 1 underflow, 2 overflow, 3 bad end depth, 4 reserved token type.
- DEPTH_CNT  out  DEPTH_W  current stack occupancy.

Behaviour:
- Reset (async, RST_N=0):
  - State goes to IDLE.
  - All outputs are 0: TOK_RDY, PUSH_STB/DAT, POP_STB, STK_CLR, RES_VLD/DAT, ERR, ERR_CODE, DEPTH_CNT.
  - TOK_RDY rises the first cycle after reset release.
- States: IDLE, POP_B, CAP_B, CAP_A, PUSH, FIN_POP, FIN_CAP, DONE, ERROR.
- TOK_RDY is 1 only in IDLE with ERR=0.
- Operand accepted in IDLE:
  - If DEPTH_CNT<DEPTH: PUSH_STB=1 with PUSH_DAT=TOK_DAT on the next cycle, DEPTH_CNT+1, stay IDLE. Back-to-back operands sustain 1 token/cycle.
  - If DEPTH_CNT==DEPTH: go to ERROR, code 2, no push.
- Operator accepted at cycle 0:
  - If DEPTH_CNT<2: go to ERROR, code 1.
  - Otherwise:
    - c1 POP_B: POP_STB=1.
    - c2 CAP_B: B=POP_DAT, POP_STB=1.
    - c3 CAP_A: A=POP_DAT, result registered.
    - c4 PUSH: PUSH_STB=1, PUSH_DAT=result, DEPTH_CNT-1.
    - c5: IDLE, TOK_RDY=1.
- Arithmetic is modulo 2^WIDTH:
  - ADD = A+B.
  - SUB = A-B, where A is the deeper operand.
  - MUL = low WIDTH bits of A*B.
  - AND = A&B.
- End accepted:
  - If DEPTH_CNT!=1: go to ERROR, code 3.
  - Otherwise:
    - c1 FIN_POP: POP_STB=1.
    - c2 FIN_CAP: capture POP_DAT.
    - c3 DONE: RES_VLD=1, RES_DAT=value, DEPTH_CNT=0.
    - c4: IDLE.
- Reserved type: go to ERROR, code 4.
- ERROR state:
  - ERR=1 and ERR_CODE are held; TOK_RDY=0.
  - No stack strobes issue; the first error code is kept.
- CLR (any state, synchronous, lower priority than reset):
  - Next cycle: state IDLE, DEPTH_CNT=0, ERR=0, ERR_CODE=0, STK_CLR=1 for exactly one cycle.
  - An in-flight operation is abandoned; no PUSH_STB is issued for it.
  - A token presented in the same cycle as CLR is not accepted.
- PUSH_STB and POP_STB are never both 1 in the same cycle.
- At most one strobe issues per cycle.

Test Plan:
- Tokens 1,5,5,MUL,ADD,END, back-to-back with TOK_VLD high -> 3 pushes on consecutive cycles, then 2 operator sequences of 5 cycles each, RES_VLD with RES_DAT=26, DEPTH_CNT=0 afterwards.
- Tokens 3,10,SUB,END -> RES_DAT=0xFFFFFFF9 (3-10 wraps); MUL of 0x10000,0x10000 -> RES_DAT=0.
- Tokens 7,ADD -> ERR=1, ERR_CODE=1, TOK_RDY=0, no POP_STB. Then pulse CLR -> STK_CLR pulses once, ERR=0, TOK_RDY=1.
- DEPTH=4; push 5 operands -> 4 PUSH_STB, ERR_CODE=2, DEPTH_CNT=4. Tokens 1,2,END -> ERR_CODE=3.
- Assert RST_N=0 during CAP_B -> all outputs 0 immediately. After release, the expression 2,3,ADD,END yields RES_DAT=5.
- TOK_TYPE=11 -> ERR_CODE=4. CLR asserted during PUSH -> no PUSH_STB that cycle or later, DEPTH_CNT=0.
